// File: rtl/rifl_rx_ctrl.sv
// RIFL receive link control: frame acceptance, in-order delivery through an AXI4-Stream FIFO,
// pause/retransmit signalling. Define RIFL_RX_ERR_CNT_EN to build the saturating error counter.
module rifl_rx_ctrl #(
  parameter int FRAME_WIDTH    = 256,
  parameter int FRAME_ID_WIDTH = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int PAUSE_ON       = 12,
  parameter int PAUSE_OFF      = 4
) (
  input  logic                      rx_frame_clk,
  input  logic                      rx_frame_rst_n,
  input  logic                      rx_aligned,
  input  logic                      frame_valid,
  input  logic                      frame_crc_ok,
  input  logic [1:0]                frame_type,
  input  logic [FRAME_ID_WIDTH-1:0] frame_id,
  input  logic [FRAME_WIDTH-1:0]    frame_data,
  input  logic                      frame_last,
  output logic [FRAME_WIDTH-1:0]    m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      rx_up,
  output logic                      rx_error,
  output logic                      rx_pause_request,
  output logic                      rx_retrans_request,
  output logic [FRAME_ID_WIDTH-1:0] expected_id,
  output logic                      remote_pause,
  output logic                      remote_retrans,
  output logic [FRAME_ID_WIDTH-1:0] remote_retrans_id,
  output logic [15:0]               err_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] PON_C   = CNT_W'(PAUSE_ON);
  localparam logic [CNT_W-1:0] POFF_C  = CNT_W'(PAUSE_OFF);

  typedef enum logic [1:0] {RX_DOWN, RX_NORMAL, RX_RETRANS_WAIT} rx_state_t;
  rx_state_t state;

  logic [FRAME_WIDTH:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count, count_nxt;

  logic active_p0, data_p0, push_p0, drop_p0, pop_p0, err_p0, ctl_ok_p0;

  // Stage p0: classify the incoming frame against the current link state
  always_comb begin
    active_p0 = rx_aligned && frame_valid && (state != RX_DOWN || frame_crc_ok);
    data_p0   = active_p0 && (frame_type == 2'd0);
    push_p0   = data_p0 && frame_crc_ok && (frame_id == expected_id) && (count != DEPTH_C);
    drop_p0   = data_p0 && !push_p0;
    ctl_ok_p0 = active_p0 && frame_crc_ok;
    // In retransmit wait, out-of-order good frames are expected noise, only CRC failures are errors
    err_p0    = (active_p0 && !frame_crc_ok) || (drop_p0 && state != RX_RETRANS_WAIT);
    pop_p0    = m_axis_tvalid && m_axis_tready;
    count_nxt = count + CNT_W'(push_p0) - CNT_W'(pop_p0);
  end

  always_ff @(posedge rx_frame_clk) begin
    if (!rx_frame_rst_n || !rx_aligned) begin
      state              <= RX_DOWN;
      rx_up              <= 1'b0;
      rx_retrans_request <= 1'b0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      expected_id        <= '0;
      rx_pause_request   <= 1'b0;
      rx_error           <= 1'b0;
      remote_pause       <= 1'b0;
      remote_retrans     <= 1'b0;
      if (!rx_frame_rst_n)
        remote_retrans_id <= '0;
    end else begin
      if (push_p0) begin
        state              <= RX_NORMAL;
        rx_up              <= 1'b1;
        rx_retrans_request <= 1'b0;
        expected_id        <= expected_id + FRAME_ID_WIDTH'(1);
        wr_ptr             <= wr_ptr + PTR_W'(1);
      end else if (drop_p0 && state != RX_RETRANS_WAIT) begin
        state              <= RX_RETRANS_WAIT;
        rx_up              <= 1'b1;
        rx_retrans_request <= 1'b1;
      end else if (active_p0 && state == RX_DOWN) begin
        state              <= RX_NORMAL;
        rx_up              <= 1'b1;
        rx_retrans_request <= 1'b0;
      end
      if (pop_p0)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      if (count_nxt >= PON_C)
        rx_pause_request <= 1'b1;
      else if (count_nxt <= POFF_C)
        rx_pause_request <= 1'b0;
      rx_error       <= err_p0;
      remote_retrans <= ctl_ok_p0 && (frame_type == 2'd3);
      if (ctl_ok_p0)
        remote_pause <= (frame_type == 2'd2);
      if (ctl_ok_p0 && frame_type == 2'd3)
        remote_retrans_id <= frame_id;
    end
  end

  always_ff @(posedge rx_frame_clk) begin
    if (rx_frame_rst_n && push_p0)
      mem[wr_ptr] <= {frame_data, frame_last};
  end

  always_comb begin
    m_axis_tvalid = (count != '0);
    {m_axis_tdata, m_axis_tlast} = m_axis_tvalid ? mem[rd_ptr] : '0;
  end

`ifdef RIFL_RX_ERR_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Survives link drops so that flapping links stay visible
  always_ff @(posedge rx_frame_clk) begin
    if (!rx_frame_rst_n)
      err_cnt <= '0;
    else if (err_p0)
      err_cnt <= sat_inc16(err_cnt);
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_rifl_rx_ctrl.sv
// Directed bench for rifl_rx_ctrl with a queue-based reference model compared every cycle.
module tb_rifl_rx_ctrl;
  localparam int FW = 256;
  localparam int IW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          aligned = 1'b0;
  logic          fv = 1'b0;
  logic          crc = 1'b0;
  logic [1:0]    ftype = 2'd0;
  logic [IW-1:0] fid = '0;
  logic [FW-1:0] fdata = '0;
  logic          flast = 1'b0;
  logic          tready = 1'b0;
  logic [FW-1:0] tdata;
  logic          tlast, tvalid;
  logic          rx_up, rx_error, rx_pause_request, rx_retrans_request;
  logic [IW-1:0] expected_id, remote_retrans_id;
  logic          remote_pause, remote_retrans;
  logic [15:0]   err_cnt;

  rifl_rx_ctrl dut (
    .rx_frame_clk(clk), .rx_frame_rst_n(rst_n), .rx_aligned(aligned),
    .frame_valid(fv), .frame_crc_ok(crc), .frame_type(ftype), .frame_id(fid),
    .frame_data(fdata), .frame_last(flast),
    .m_axis_tdata(tdata), .m_axis_tlast(tlast), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .rx_up(rx_up), .rx_error(rx_error), .rx_pause_request(rx_pause_request),
    .rx_retrans_request(rx_retrans_request), .expected_id(expected_id),
    .remote_pause(remote_pause), .remote_retrans(remote_retrans),
    .remote_retrans_id(remote_retrans_id), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Reference model state: link up / waiting for resend, receive queue, status flags
  logic [FW:0]   m_q[$];
  bit            m_up, m_wait, m_rpause, m_preq, m_err, m_rretr;
  logic [IW-1:0] m_exp, m_rid;
  int            m_errcnt;

  task automatic chk(input string name, input logic [FW:0] act, input logic [FW:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mkdata(input logic [IW-1:0] id);
    return {8{{24'hC0FFEE, id}}};
  endfunction

  task automatic model_step();
    bit acc, pop;
    m_err = 1'b0;
    m_rretr = 1'b0;
    if (!rst_n) begin
      m_q.delete(); m_up = 0; m_wait = 0; m_exp = '0; m_rpause = 0; m_preq = 0;
      m_rid = '0; m_errcnt = 0;
      return;
    end
    if (!aligned) begin
      m_q.delete(); m_up = 0; m_wait = 0; m_exp = '0; m_rpause = 0; m_preq = 0;
      return;
    end
    acc = 1'b0;
    pop = (m_q.size() != 0) && tready;
    if (fv && (m_up || crc)) begin
      if (crc) begin
        m_up = 1;
        m_rpause = (ftype == 2'd2);
        if (ftype == 2'd3) begin
          m_rretr = 1; m_rid = fid;
        end
      end
      if (ftype == 2'd0) begin
        if (crc && fid == m_exp && m_q.size() < DEPTH) begin
          acc = 1'b1; m_exp = m_exp + 1'b1; m_wait = 0;
        end else begin
          m_err = !crc || !m_wait;
          m_wait = 1;
        end
      end else if (!crc) begin
        m_err = 1;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back({fdata, flast});
    if (m_q.size() >= 12) m_preq = 1;
    else if (m_q.size() <= 4) m_preq = 0;
    if (m_err && m_errcnt < 16'hFFFF) m_errcnt++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [FW:0] head;
      head = (m_q.size() != 0) ? m_q[0] : '0;
      chk("rx_up", rx_up, m_up);
      chk("rx_retrans_request", rx_retrans_request, m_wait);
      chk("rx_error", rx_error, m_err);
      chk("rx_pause_request", rx_pause_request, m_preq);
      chk("expected_id", expected_id, m_exp);
      chk("remote_pause", remote_pause, m_rpause);
      chk("remote_retrans", remote_retrans, m_rretr);
      chk("remote_retrans_id", remote_retrans_id, m_rid);
      chk("tvalid", tvalid, m_q.size() != 0);
      chk("beat", {tdata, tlast}, head);
`ifdef RIFL_RX_ERR_CNT_EN
      chk("err_cnt", err_cnt, m_errcnt);
`else
      chk("err_cnt", err_cnt, 0);
`endif
    end
  end

  // One clock: inputs are applied after a falling edge, model advances on the rising edge
  task automatic frame(input bit v, input bit ok, input logic [1:0] ty, input logic [IW-1:0] id);
    fv = v; crc = ok; ftype = ty; fid = id; fdata = mkdata(id); flast = id[0];
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
    @(negedge clk);
    fv = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) frame(0, 0, 2'd0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frame(1, 1, 2'd0, 8'd0);
    frame(1, 1, 2'd2, 8'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();
    chk("lit_reset_up", rx_up, 0);
    chk("lit_reset_tvalid", tvalid, 0);
    chk("lit_reset_exp", expected_id, 0);
    chk("lit_reset_errcnt", err_cnt, 0);

    // In-order delivery of three good frames
    aligned = 1'b1; tready = 1'b1;
    for (int i = 0; i < 3; i++) frame(1, 1, 2'd0, IW'(i));
    idle(2);
    chk("lit_basic_up", rx_up, 1);
    chk("lit_basic_exp", expected_id, 3);
    chk("lit_basic_drained", tvalid, 0);

    // Sequence gap, then resend
    do_reset();
    frame(1, 1, 2'd0, 8'd0);
    frame(1, 1, 2'd0, 8'd1);
    frame(1, 1, 2'd0, 8'd3);
    chk("lit_gap_err", rx_error, 1);
    chk("lit_gap_req", rx_retrans_request, 1);
    chk("lit_gap_exp", expected_id, 2);
    frame(1, 1, 2'd0, 8'd5);
    chk("lit_wait_noerr", rx_error, 0);
    frame(1, 0, 2'd0, 8'd2);
    chk("lit_wait_crcerr", rx_error, 1);
    frame(1, 1, 2'd0, 8'd2);
    chk("lit_resend_req", rx_retrans_request, 0);
    chk("lit_resend_exp", expected_id, 3);
    idle(2);

    // Remote control frames
    frame(1, 1, 2'd2, 8'd0);
    chk("lit_rpause_set", remote_pause, 1);
    frame(1, 0, 2'd1, 8'd0);
    chk("lit_ctl_crc_err", rx_error, 1);
    chk("lit_ctl_crc_hold", remote_pause, 1);
    frame(1, 1, 2'd1, 8'd0);
    chk("lit_rpause_clr", remote_pause, 0);
    frame(1, 1, 2'd3, 8'h5A);
    chk("lit_rretr_pulse", remote_retrans, 1);
    chk("lit_rretr_id", remote_retrans_id, 8'h5A);
    idle(1);
    chk("lit_rretr_done", remote_retrans, 0);

    // Fill, pause hysteresis, overflow protection
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 11; i++) frame(1, 1, 2'd0, IW'(i));
    chk("lit_pause_11", rx_pause_request, 0);
    frame(1, 1, 2'd0, 8'd11);
    chk("lit_pause_12", rx_pause_request, 1);
    tready = 1'b1;
    idle(7);
    chk("lit_pause_hold5", rx_pause_request, 1);
    idle(1);
    chk("lit_pause_clr4", rx_pause_request, 0);
    tready = 1'b0;
    for (int i = 12; i < 24; i++) frame(1, 1, 2'd0, IW'(i));
    frame(1, 1, 2'd0, 8'd24);
    chk("lit_full_err", rx_error, 1);
    chk("lit_full_req", rx_retrans_request, 1);
    chk("lit_full_exp", expected_id, 24);
    tready = 1'b1;
    idle(17);
    frame(1, 1, 2'd0, 8'd24);
    chk("lit_full_resend", expected_id, 25);
    idle(2);

    // Link loss with frames stored
    tready = 1'b0;
    for (int i = 25; i < 30; i++) frame(1, 1, 2'd0, IW'(i));
    aligned = 1'b0;
    idle(1);
    chk("lit_loss_tvalid", tvalid, 0);
    chk("lit_loss_up", rx_up, 0);
    chk("lit_loss_exp", expected_id, 0);
    aligned = 1'b1;
    frame(1, 0, 2'd0, 8'd0);
    chk("lit_down_ignore", rx_error, 0);
    frame(1, 1, 2'd0, 8'd0);
    chk("lit_relock_up", rx_up, 1);
    frame(1, 1, 2'd0, 8'd1);

    // Reset mid-operation, then count CRC failures
    do_reset();
    chk("lit_midrst_tvalid", tvalid, 0);
    chk("lit_midrst_errcnt", err_cnt, 0);
    tready = 1'b1;
    frame(1, 1, 2'd0, 8'd0);
    for (int i = 0; i < 3; i++) frame(1, 0, 2'd0, 8'd1);
    idle(1);
`ifdef RIFL_RX_ERR_CNT_EN
    chk("lit_errcnt", err_cnt, 3);
`else
    chk("lit_errcnt", err_cnt, 0);
`endif
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rifl_rx_ctrl.md
RIFL_RX_CTRL -- requirements
Module: rifl_rx_ctrl

Interface
REQ-001 SHALL have parameters: FRAME_WIDTH, default 256, payload bits per frame; FRAME_ID_WIDTH, default 8, frame sequence-number width; FIFO_DEPTH, default 16, power of 2, receive buffer depth; PAUSE_ON, default 12, fill level that raises pause; PAUSE_OFF, default 4, fill level that releases pause (PAUSE_OFF < PAUSE_ON < FIFO_DEPTH).
REQ-002 SHALL have ports: rx_frame_clk, in, 1, sole clock; rx_frame_rst_n, in, 1, synchronous active-low reset.
REQ-003 SHALL have ports: rx_aligned, in, 1, deframer lock; frame_valid, in, 1, one decoded frame this cycle; frame_crc_ok, in, 1, CRC pass; frame_type, in, 2, 0=data 1=idle 2=pause 3=retrans; frame_id, in, FRAME_ID_WIDTH, frame sequence number; frame_data, in, FRAME_WIDTH, payload; frame_last, in, 1, packet end.
REQ-004 SHALL have ports: m_axis_tdata, out, FRAME_WIDTH; m_axis_tlast, out, 1; m_axis_tvalid, out, 1; m_axis_tready, in, 1.
REQ-005 SHALL have ports: rx_up, out, 1; rx_error, out, 1, one-cycle pulse per rejected frame; rx_pause_request, out, 1, local buffer pressure; rx_retrans_request, out, 1; expected_id, out, FRAME_ID_WIDTH; remote_pause, out, 1; remote_retrans, out, 1, pulse; remote_retrans_id, out, FRAME_ID_WIDTH; err_cnt, out, 16.

Function
REQ-006 SHALL implement FSM states RX_DOWN, RX_NORMAL, RX_RETRANS_WAIT.
REQ-007 RX_DOWN -> RX_NORMAL on first frame_valid with frame_crc_ok while rx_aligned; that frame is processed normally in the same cycle.
REQ-008 Any state -> RX_DOWN when rx_aligned = 0; entry flushes FIFO, clears expected_id to 0, clears remote_pause and rx_pause_request.
REQ-009 RX_NORMAL: data frame with crc ok, frame_id == expected_id, FIFO not full -> write {frame_data, frame_last} to FIFO, expected_id increments modulo 2^FRAME_ID_WIDTH.
REQ-010 RX_NORMAL: data frame with CRC fail, frame_id != expected_id, or FIFO full -> drop, pulse rx_error, go to RX_RETRANS_WAIT; expected_id unchanged.
REQ-011 RX_RETRANS_WAIT: rx_retrans_request = 1; drop all data frames except one with crc ok and frame_id == expected_id and FIFO not full, which is accepted per REQ-009 and returns FSM to RX_NORMAL; each dropped data frame with CRC fail pulses rx_error.
REQ-012 rx_retrans_request SHALL be 0 outside RX_RETRANS_WAIT; rx_up SHALL be 1 exactly when state != RX_DOWN.
REQ-013 Control frames (types 1-3) with CRC fail SHALL be dropped and pulse rx_error without a state change; with crc ok they never enter the FIFO.
REQ-014 Type 2 with crc ok sets remote_pause; any other crc-ok frame type clears it.
REQ-015 Type 3 with crc ok pulses remote_retrans for one cycle, registering frame_id to remote_retrans_id.
REQ-016 Status outputs (rx_error, remote_*) SHALL be registered, one cycle after the frame_valid cycle.
REQ-017 FIFO output SHALL follow AXI4-Stream: tvalid = FIFO non-empty; tdata/tlast stable while tvalid & !tready; pop on tvalid & tready; simultaneous push and pop keeps count constant; first-word latency one cycle after write.
REQ-018 rx_pause_request sets when count >= PAUSE_ON and clears when count <= PAUSE_OFF; otherwise holds.
REQ-019 Outside RX_DOWN, FIFO SHALL never overflow or underflow.

Reset
REQ-020 On rx_frame_rst_n = 0 at a clock edge: state RX_DOWN, FIFO empty, expected_id 0, all outputs 0 (err_cnt 0, tvalid 0), mid-operation included; inputs ignored that cycle.

Configuration
REQ-021 Macro RIFL_RX_ERR_CNT_EN: defined -> err_cnt counts rx_error pulses, saturating at 16'hFFFF, cleared only by reset; undefined -> err_cnt constant 0 and no counter logic.

Verification
REQ-022 Reset, rx_aligned=1, data ids 0,1,2 crc ok, tready=1 -> rx_up=1, three beats out in order, expected_id=3.
REQ-023 Data ids 0,1 then id 3 -> id 3 dropped, rx_error one pulse, rx_retrans_request=1, expected_id=2; resend id 2 -> request clears, id 2 output.
REQ-024 tready=0, 12 good data frames -> rx_pause_request=1 at count 12; tready=1 until count 4 -> clears; 17th frame with 16 stored -> dropped, retrans.
REQ-025 Type 2 crc ok -> remote_pause=1; then type 1 -> 0; type 3 id 0x5A -> remote_retrans one pulse, remote_retrans_id=0x5A.
REQ-026 rx_aligned drops with 5 frames stored -> FIFO empty, tvalid=0, rx_up=0, expected_id=0 next cycle.
REQ-027 With RIFL_RX_ERR_CNT_EN, 3 CRC-fail frames -> err_cnt=3; without it -> err_cnt=0.
